// File: rtl/autosa_shift_pkg.sv
// Shared definitions for the AUTOSA multi-lane shift/round/saturate pipeline.
// Holds the rounding-mode encodings and constant functions that derive the
// signed saturation limits from an output width. No ports.
package autosa_shift_pkg;

    localparam logic [1:0] RMODE_NEAREST_AWAY = 2'd0;
    localparam logic [1:0] RMODE_TRUNC        = 2'd1;
    localparam logic [1:0] RMODE_HALF_EVEN    = 2'd2;

    // Largest positive value representable in out_w signed bits, as 64 bits.
    function automatic logic signed [63:0] sat_max_f(input int unsigned out_w);
        sat_max_f = (64'sd1 <<< (out_w - 32'd1)) - 64'sd1;
    endfunction

    // Most negative value representable in out_w signed bits, as 64 bits.
    function automatic logic signed [63:0] sat_min_f(input int unsigned out_w);
        sat_min_f = -(64'sd1 <<< (out_w - 32'd1));
    endfunction

endpackage

// File: rtl/autosa_hls_shiftrightss_lane.sv
// Per-lane combinational datapath of the shift/round/saturate pipeline.
// The shift half (stage 1) and the round/saturate half (stage 2) are kept as
// two independent functions; the top level places its registers between them.
// Ports:
//   i_val, i_shift          : lane input value and signed shift count (stage 1)
//   o_s1_*                  : shifted value, guide, sticky, input sign, overflow
//   i_s2_*, i_s2_rmode      : registered stage-1 fields and rounding mode
//   o_res, o_sat            : OUT_WIDTH result and saturation flag (stage 2)
module autosa_hls_shiftrightss_lane
    import autosa_shift_pkg::*;
#(
    parameter int IN_WIDTH    = 49,
    parameter int OUT_WIDTH   = 32,
    parameter int SHIFT_WIDTH = 7
) (
    input  logic signed [IN_WIDTH-1:0]    i_val,
    input  logic signed [SHIFT_WIDTH-1:0] i_shift,
    output logic [IN_WIDTH-1:0]           o_s1_val,
    output logic                          o_s1_guide,
    output logic                          o_s1_sticky,
    output logic                          o_s1_sign,
    output logic                          o_s1_ovf,
    input  logic [IN_WIDTH-1:0]           i_s2_val,
    input  logic                          i_s2_guide,
    input  logic                          i_s2_sticky,
    input  logic                          i_s2_sign,
    input  logic                          i_s2_ovf,
    input  logic [1:0]                    i_s2_rmode,
    output logic [OUT_WIDTH-1:0]          o_res,
    output logic                          o_sat
);

    // Sign extension is wide enough that even the largest left shift keeps
    // the original sign bit inside the vector, so overflow is exact.
    localparam int EXT_W = IN_WIDTH + 2**(SHIFT_WIDTH-1);

    localparam logic [SHIFT_WIDTH-1:0]   ONE_SH  = SHIFT_WIDTH'(1);
    localparam logic [IN_WIDTH-1:0]      ONE_IN  = IN_WIDTH'(1);
    localparam logic signed [IN_WIDTH:0] SUM_MAX = (IN_WIDTH+1)'(sat_max_f(OUT_WIDTH));
    localparam logic signed [IN_WIDTH:0] SUM_MIN = (IN_WIDTH+1)'(sat_min_f(OUT_WIDTH));
    localparam logic [OUT_WIDTH-1:0]     OUT_MAX = OUT_WIDTH'(sat_max_f(OUT_WIDTH));
    localparam logic [OUT_WIDTH-1:0]     OUT_MIN = OUT_WIDTH'(sat_min_f(OUT_WIDTH));

    typedef struct packed {
        logic [IN_WIDTH-1:0] val;
        logic                guide;
        logic                sticky;
        logic                sign;
        logic                ovf;
    } s1_t;

    typedef struct packed {
        logic [OUT_WIDTH-1:0] res;
        logic                 sat;
    } s2_t;

    function automatic s1_t shift_f(input logic signed [IN_WIDTH-1:0]    v,
                                    input logic signed [SHIFT_WIDTH-1:0] sh);
        s1_t                     r;
        logic [SHIFT_WIDTH-1:0]  mag;
        logic signed [EXT_W-1:0] ext;
        r      = '0;
        r.sign = v[IN_WIDTH-1];
        if (!sh[SHIFT_WIDTH-1]) begin
            mag = sh;
            if (int'(mag) >= IN_WIDTH) begin
                // Everything shifted out: result is zero regardless of sign.
                r.val = '0;
            end else if (mag == '0) begin
                r.val = v;
            end else begin
                r.val    = v >>> mag;
                r.guide  = |(v & (ONE_IN << (mag - ONE_SH)));
                r.sticky = |(v & ~({IN_WIDTH{1'b1}} << (mag - ONE_SH)));
            end
        end else begin
            // Negating the count yields its magnitude, including the most
            // negative count, when read as unsigned.
            mag   = -sh;
            ext   = EXT_W'(v);
            ext   = ext <<< mag;
            r.ovf = (ext[EXT_W-1:OUT_WIDTH-1] != {(EXT_W-OUT_WIDTH+1){v[IN_WIDTH-1]}});
            r.val = ext[IN_WIDTH-1:0];
        end
        return r;
    endfunction

    function automatic s2_t round_f(input s1_t s, input logic [1:0] rm);
        s2_t                     r;
        logic                    rup;
        logic signed [IN_WIDTH:0] sum;
        case (rm)
            RMODE_NEAREST_AWAY: rup = s.guide & (~s.sign | s.sticky);
            RMODE_TRUNC:        rup = 1'b0;
            RMODE_HALF_EVEN:    rup = s.guide & (s.sticky | s.val[0]);
            default:            rup = s.guide & (~s.sign | s.sticky);
        endcase
        sum   = $signed({s.val[IN_WIDTH-1], s.val}) + $signed({{IN_WIDTH{1'b0}}, rup});
        r.sat = s.ovf | (sum > SUM_MAX) | (sum < SUM_MIN);
        if (r.sat) begin
            r.res = s.sign ? OUT_MIN : OUT_MAX;
        end else begin
            r.res = sum[OUT_WIDTH-1:0];
        end
        return r;
    endfunction

    s1_t w_s1;
    s1_t w_s2_in;
    s2_t w_s2;

    // Stage-1 shift of the incoming lane value.
    always_comb begin
        w_s1 = shift_f(i_val, i_shift);
    end

    assign o_s1_val    = w_s1.val;
    assign o_s1_guide  = w_s1.guide;
    assign o_s1_sticky = w_s1.sticky;
    assign o_s1_sign   = w_s1.sign;
    assign o_s1_ovf    = w_s1.ovf;

    assign w_s2_in = {i_s2_val, i_s2_guide, i_s2_sticky, i_s2_sign, i_s2_ovf};

    // Stage-2 rounding and saturation of the registered stage-1 fields.
    always_comb begin
        w_s2 = round_f(w_s2_in, i_s2_rmode);
    end

    assign o_res = w_s2.res;
    assign o_sat = w_s2.sat;

endmodule

// File: rtl/autosa_hls_shiftrightss_pipe.sv
// Multi-lane, two-stage pipelined signed shift / round / saturate block.
// Ports:
//   autosa_core_clk/rstn      : clock, asynchronous active-low reset
//   in_pvld/in_prdy, in_data  : input beat handshake and LANES packed lanes
//   in_shift, in_rmode        : per-beat signed shift count and rounding mode
//   out_pvld/out_prdy         : output beat handshake
//   out_data, out_sat         : packed results and per-lane saturation flags
//   sat_cnt, sat_cnt_clr      : saturating count of saturated lanes, clear
module autosa_hls_shiftrightss_pipe
    import autosa_shift_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int IN_WIDTH    = 49,
    parameter int OUT_WIDTH   = 32,
    parameter int SHIFT_WIDTH = 7,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                          autosa_core_clk,
    input  logic                          autosa_core_rstn,
    input  logic                          in_pvld,
    output logic                          in_prdy,
    input  logic [LANES*IN_WIDTH-1:0]     in_data,
    input  logic signed [SHIFT_WIDTH-1:0] in_shift,
    input  logic [1:0]                    in_rmode,
    output logic                          out_pvld,
    input  logic                          out_prdy,
    output logic [LANES*OUT_WIDTH-1:0]    out_data,
    output logic [LANES-1:0]              out_sat,
    output logic [CNT_WIDTH-1:0]          sat_cnt,
    input  logic                          sat_cnt_clr
);

    function automatic logic [CNT_WIDTH:0] popcount_f(input logic [LANES-1:0] v);
        logic [CNT_WIDTH:0] c;
        c = '0;
        for (int i = 0; i < LANES; i++) begin
            c = c + {{CNT_WIDTH{1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic                       r_s1_vld;
    logic [LANES*IN_WIDTH-1:0]  r_s1_val;
    logic [LANES-1:0]           r_s1_guide;
    logic [LANES-1:0]           r_s1_sticky;
    logic [LANES-1:0]           r_s1_sign;
    logic [LANES-1:0]           r_s1_ovf;
    logic [1:0]                 r_s1_rmode;
    logic                       r_s2_vld;
    logic [LANES*OUT_WIDTH-1:0] r_s2_data;
    logic [LANES-1:0]           r_s2_sat;
    logic [CNT_WIDTH-1:0]       r_sat_cnt;

    logic [LANES*IN_WIDTH-1:0]  w_s1_val;
    logic [LANES-1:0]           w_s1_guide;
    logic [LANES-1:0]           w_s1_sticky;
    logic [LANES-1:0]           w_s1_sign;
    logic [LANES-1:0]           w_s1_ovf;
    logic [LANES*OUT_WIDTH-1:0] w_res;
    logic [LANES-1:0]           w_sat;
    logic                       w_s1_adv;
    logic                       w_s2_load;
    logic                       w_xfer;
    logic [CNT_WIDTH:0]         w_pop;
    logic [CNT_WIDTH:0]         w_cnt_sum;
    logic [CNT_WIDTH-1:0]       w_cnt_nxt;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        autosa_hls_shiftrightss_lane #(
            .IN_WIDTH    (IN_WIDTH),
            .OUT_WIDTH   (OUT_WIDTH),
            .SHIFT_WIDTH (SHIFT_WIDTH)
        ) u_lane (
            .i_val       (in_data[g*IN_WIDTH +: IN_WIDTH]),
            .i_shift     (in_shift),
            .o_s1_val    (w_s1_val[g*IN_WIDTH +: IN_WIDTH]),
            .o_s1_guide  (w_s1_guide[g]),
            .o_s1_sticky (w_s1_sticky[g]),
            .o_s1_sign   (w_s1_sign[g]),
            .o_s1_ovf    (w_s1_ovf[g]),
            .i_s2_val    (r_s1_val[g*IN_WIDTH +: IN_WIDTH]),
            .i_s2_guide  (r_s1_guide[g]),
            .i_s2_sticky (r_s1_sticky[g]),
            .i_s2_sign   (r_s1_sign[g]),
            .i_s2_ovf    (r_s1_ovf[g]),
            .i_s2_rmode  (r_s1_rmode),
            .o_res       (w_res[g*OUT_WIDTH +: OUT_WIDTH]),
            .o_sat       (w_sat[g])
        );
    end

    // Stage 1 may take a beat whenever it is empty or will drain this cycle.
    assign w_s1_adv  = ~r_s1_vld | ~r_s2_vld | out_prdy;
    assign w_s2_load = r_s1_vld & (~r_s2_vld | out_prdy);
    assign in_prdy   = w_s1_adv;
    assign w_xfer    = r_s2_vld & out_prdy;
    assign w_pop     = popcount_f(r_s2_sat);
    assign w_cnt_sum = {1'b0, r_sat_cnt} + w_pop;

    // Stage-1 register: shifted lane fields plus the beat's rounding mode.
    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            r_s1_vld    <= 1'b0;
            r_s1_val    <= '0;
            r_s1_guide  <= '0;
            r_s1_sticky <= '0;
            r_s1_sign   <= '0;
            r_s1_ovf    <= '0;
            r_s1_rmode  <= 2'd0;
        end else if (w_s1_adv) begin
            r_s1_vld <= in_pvld;
            if (in_pvld) begin
                r_s1_val    <= w_s1_val;
                r_s1_guide  <= w_s1_guide;
                r_s1_sticky <= w_s1_sticky;
                r_s1_sign   <= w_s1_sign;
                r_s1_ovf    <= w_s1_ovf;
                r_s1_rmode  <= in_rmode;
            end
        end
    end

    // Stage-2 register: rounded, saturated results held until accepted.
    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            r_s2_vld  <= 1'b0;
            r_s2_data <= '0;
            r_s2_sat  <= '0;
        end else if (w_s2_load) begin
            r_s2_vld  <= 1'b1;
            r_s2_data <= w_res;
            r_s2_sat  <= w_sat;
        end else if (out_prdy) begin
            r_s2_vld  <= 1'b0;
        end
    end

    // Next saturation count: clear wins over history but keeps this beat.
    always_comb begin
        if (sat_cnt_clr) begin
            if (w_xfer) begin
                w_cnt_nxt = w_pop[CNT_WIDTH-1:0];
            end else begin
                w_cnt_nxt = '0;
            end
        end else if (w_xfer) begin
            if (w_cnt_sum[CNT_WIDTH]) begin
                w_cnt_nxt = '1;
            end else begin
                w_cnt_nxt = w_cnt_sum[CNT_WIDTH-1:0];
            end
        end else begin
            w_cnt_nxt = r_sat_cnt;
        end
    end

    // Saturation event counter register.
    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            r_sat_cnt <= '0;
        end else begin
            r_sat_cnt <= w_cnt_nxt;
        end
    end

    assign out_pvld = r_s2_vld;
    assign out_data = r_s2_data;
    assign out_sat  = r_s2_sat;
    assign sat_cnt  = r_sat_cnt;

endmodule
